reg_dump: RTL

Debug readout engine for the CPU register file's test read port. On a start pulse it walks the test address from the first to the last register, captures each combinational read word, and presents it on a valid/ready output stream tagged with its register number. It sits between the register file's `ratest`/`rdtest` pair and a debug consumer such as a display driver or serial link, and it is the reader for that port.

---
 rtl/reg_dump.sv | 123 ++++++++++++
 1 files changed

// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the register file test read port.
//
// On a start pulse it walks the test address from the first register to LAST.
// Each word is captured from the combinational read port, then offered on a
// valid/ready stream tagged with its register index.
//
// Optional feature: define REG_DUMP_SKIP_ZERO_EN to start the walk at index 1,
// because register 0 is hardwired to zero.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      dump request, sampled only in IDLE
//   ratest     address to the register file test port
//   rdtest     combinational read data for ratest
//   out_valid  payload below is valid
//   out_ready  consumer accepts the word when high together with out_valid
//   out_data   captured register value
//   out_addr   index of the captured register
//   out_last   current word is the final word of the dump
//   busy       high in LOAD, SEND and DONE
//   done       one-cycle pulse after the final handshake
module reg_dump #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned LAST = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ratest,
  input  logic [DW-1:0] rdtest,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam logic [AW-1:0] FirstIdx = AW'(1);
`else
  localparam logic [AW-1:0] FirstIdx = '0;
`endif
  localparam logic [AW-1:0] LastIdx = AW'(LAST);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_q, last_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        ptr_d = FirstIdx;
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Each word is a live read; there is no snapshot of the whole file.
        data_d  = rdtest;
        addr_d  = ptr_q;
        last_d  = (ptr_q == LastIdx);
        state_d = StSend;
      end
      StSend: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            // Never reached past LastIdx, so ptr cannot wrap.
            ptr_d   = ptr_q + AW'(1);
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        ptr_d   = FirstIdx;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        ptr_d   = FirstIdx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= FirstIdx;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign ratest    = ptr_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule
